// File: rtl/apb2axil_pkg.sv
// Shared definitions for the APB to AXI4-Lite bridge.
//   state_t        : bridge FSM states
//   RESP_*         : AXI response encodings
//   resp_is_error  : maps an AXI response onto the APB pslverr flag
package apb2axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WREQ,
        WRSP,
        RREQ,
        RRSP,
        DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic resp_is_error(input logic [1:0] resp);
        case (resp)
            RESP_OKAY, RESP_EXOKAY:   return 1'b0;
            RESP_SLVERR, RESP_DECERR: return 1'b1;
            default:                  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/apb2axil_bridge.sv
// APB completer to AXI4-Lite manager bridge.
// One APB access at a time becomes one AXI4-Lite write (AW+W+B) or read
// (AR+R); pready is held low until the AXI response has come back.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   psel/penable/pwrite      APB control
//   paddr/pwdata/pprot       APB address, write data, protection
//   pstrb                    APB write strobes (APB2AXIL_PSTRB_EN only)
//   pready/prdata/pslverr    APB completion, read data, error
//   aw*, w*, b*              AXI4-Lite write channels
//   ar*, r*                  AXI4-Lite read channels
//
// Build option: APB2AXIL_PSTRB_EN adds the pstrb port and forwards it to
// wstrb; without it every write uses all byte lanes.
module apb2axil_bridge
    import apb2axil_pkg::*;
#(
    parameter int dataWidth = 32,
    parameter int addrWidth = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   psel,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [addrWidth-1:0]   paddr,
    input  logic [dataWidth-1:0]   pwdata,
    input  logic [2:0]             pprot,
`ifdef APB2AXIL_PSTRB_EN
    input  logic [dataWidth/8-1:0] pstrb,
`endif
    output logic                   pready,
    output logic [dataWidth-1:0]   prdata,
    output logic                   pslverr,
    output logic [addrWidth-1:0]   awaddr,
    output logic [2:0]             awprot,
    output logic                   awvalid,
    input  logic                   awready,
    output logic [dataWidth-1:0]   wdata,
    output logic [dataWidth/8-1:0] wstrb,
    output logic                   wvalid,
    input  logic                   wready,
    input  logic [1:0]             bresp,
    input  logic                   bvalid,
    output logic                   bready,
    output logic [addrWidth-1:0]   araddr,
    output logic [2:0]             arprot,
    output logic                   arvalid,
    input  logic                   arready,
    input  logic [dataWidth-1:0]   rdata,
    input  logic [1:0]             rresp,
    input  logic                   rvalid,
    output logic                   rready
);

    state_t               state;
    logic [addrWidth-1:0] addr_q;
    logic [dataWidth-1:0] data_q;
    logic [2:0]           prot_q;
    logic                 aw_done;
    logic                 w_done;
    logic                 accept;
    logic                 aw_acc;
    logic                 w_acc;

    // pready is still high in the first IDLE cycle while the master is
    // finishing the transfer, so that cycle must not start a new access.
    always_comb begin
        accept = (state == IDLE) && psel && penable && !pready;
        aw_acc = aw_done || (awvalid && awready);
        w_acc  = w_done  || (wvalid  && wready);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= paddr;
            data_q <= pwdata;
            prot_q <= pprot;
        end
    end

`ifdef APB2AXIL_PSTRB_EN
    logic [dataWidth/8-1:0] strb_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            strb_q <= pstrb;
        end
    end

    assign wstrb = strb_q;
`else
    assign wstrb = '1;
`endif

    assign awaddr = addr_q;
    assign araddr = addr_q;
    assign wdata  = data_q;
    assign awprot = prot_q;
    assign arprot = prot_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    if (accept) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (pwrite) begin
                            prdata  <= '0;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WREQ;
                        end else begin
                            arvalid <= 1'b1;
                            state   <= RREQ;
                        end
                    end
                end
                WREQ: begin
                    // AW and W are accepted independently, in either order.
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    aw_done <= aw_acc;
                    w_done  <= w_acc;
                    if (aw_acc && w_acc) begin
                        bready <= 1'b1;
                        state  <= WRSP;
                    end
                end
                WRSP: begin
                    if (bvalid) begin
                        pslverr <= resp_is_error(bresp);
                        bready  <= 1'b0;
                        state   <= DONE;
                    end
                end
                RREQ: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RRSP;
                    end
                end
                RRSP: begin
                    if (rvalid) begin
                        prdata  <= rdata;
                        pslverr <= resp_is_error(rresp);
                        rready  <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    pready <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb2axil_bridge.sv
`timescale 1ns/1ps
module tb_apb2axil_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [2:0]  pprot = '0;
`ifdef APB2AXIL_PSTRB_EN
    logic [3:0]  pstrb = '0;
`endif
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic [31:0] rdata = '0;

    always #5 clk = ~clk;

    apb2axil_bridge #(.dataWidth(32), .addrWidth(32)) dut (
        .clk(clk), .rst(rst_n),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pprot(pprot),
`ifdef APB2AXIL_PSTRB_EN
        .pstrb(pstrb),
`endif
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int unsigned aw_dly, w_dly, b_dly, ar_dly, r_dly;
    } txn_t;

    txn_t cur;
    int compared = 0;
    int mismatched = 0;

    // scoreboard queues: {addr,prot}, {data,strb}, {pslverr,prdata}
    logic [34:0] exp_aw[$];
    logic [34:0] exp_ar[$];
    logic [35:0] exp_w[$];
    logic [32:0] exp_apb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rules: SLVERR/DECERR are errors, writes read back zero,
    // wstrb is the APB strobe when strobes exist, otherwise all lanes.
    function automatic logic ref_err(input logic [1:0] r);
        return (r == 2'd2) || (r == 2'd3);
    endfunction

    function automatic logic [3:0] ref_strb(input logic [3:0] s);
`ifdef APB2AXIL_PSTRB_EN
        return s;
`else
        return (s & 4'h0) | 4'hF;
`endif
    endfunction

    // ---------------- AXI4-Lite subordinate model (drives at negedge) ----
    initial begin : slave
        int unsigned aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        logic s_aw, s_w, s_ar, b_fire, r_fire;
        logic [34:0] ea;
        logic [35:0] ew;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        s_aw = 0; s_w = 0; s_ar = 0; b_fire = 0; r_fire = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                s_aw = 0; s_w = 0; s_ar = 0; b_fire = 0; r_fire = 0;
                continue;
            end
            // AW: a ready raised last negedge has completed its handshake
            if (awready) awready = 0;
            else if (awvalid && !s_aw) begin
                if (aw_cnt >= cur.aw_dly) begin
                    awready = 1; s_aw = 1;
                    if (exp_aw.size() == 0) check("aw_unexpected", 64'(1), 64'(0));
                    else begin
                        ea = exp_aw.pop_front();
                        check("awaddr", 64'(awaddr), 64'(ea[34:3]));
                        check("awprot", 64'(awprot), 64'(ea[2:0]));
                    end
                end else aw_cnt++;
            end
            if (wready) wready = 0;
            else if (wvalid && !s_w) begin
                if (w_cnt >= cur.w_dly) begin
                    wready = 1; s_w = 1;
                    if (exp_w.size() == 0) check("w_unexpected", 64'(1), 64'(0));
                    else begin
                        ew = exp_w.pop_front();
                        check("wdata", 64'(wdata), 64'(ew[35:4]));
                        check("wstrb", 64'(wstrb), 64'(ew[3:0]));
                    end
                end else w_cnt++;
            end
            if (b_fire) begin
                bvalid = 0; b_fire = 0; s_aw = 0; s_w = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            end else if (s_aw && s_w && !awready && !wready) begin
                if (!bvalid) begin
                    if (b_cnt >= cur.b_dly) begin bvalid = 1; bresp = cur.resp; end
                    else b_cnt++;
                end
                if (bvalid && bready) b_fire = 1;
            end
            // AR / R
            if (arready) arready = 0;
            else if (arvalid && !s_ar) begin
                if (ar_cnt >= cur.ar_dly) begin
                    arready = 1; s_ar = 1;
                    if (exp_ar.size() == 0) check("ar_unexpected", 64'(1), 64'(0));
                    else begin
                        ea = exp_ar.pop_front();
                        check("araddr", 64'(araddr), 64'(ea[34:3]));
                        check("arprot", 64'(arprot), 64'(ea[2:0]));
                    end
                end else ar_cnt++;
            end
            if (r_fire) begin
                rvalid = 0; r_fire = 0; s_ar = 0; ar_cnt = 0; r_cnt = 0;
            end else if (s_ar && !arready) begin
                if (!rvalid) begin
                    if (r_cnt >= cur.r_dly) begin
                        rvalid = 1; rdata = cur.rdata; rresp = cur.resp;
                    end else r_cnt++;
                end
                if (rvalid && rready) r_fire = 1;
            end
        end
    end

    // ---------------- protocol / APB response monitor --------------------
    initial begin : monitor
        logic p_aw, p_w, p_ar, p_pready;
        logic [31:0] p_awaddr, p_wdata, p_araddr;
        logic [32:0] e;
        p_aw = 0; p_w = 0; p_ar = 0; p_pready = 0;
        p_awaddr = '0; p_wdata = '0; p_araddr = '0;
        forever begin
            @(negedge clk); #1;
            if (!rst_n) begin
                p_aw = 0; p_w = 0; p_ar = 0; p_pready = 0;
                continue;
            end
            if (p_aw) begin
                check("awvalid_hold", 64'(awvalid), 64'(1));
                check("awaddr_stable", 64'(awaddr), 64'(p_awaddr));
            end
            if (p_w) begin
                check("wvalid_hold", 64'(wvalid), 64'(1));
                check("wdata_stable", 64'(wdata), 64'(p_wdata));
            end
            if (p_ar) begin
                check("arvalid_hold", 64'(arvalid), 64'(1));
                check("araddr_stable", 64'(araddr), 64'(p_araddr));
            end
            if (bready) check("bready_after_aw_w", 64'({awvalid, wvalid}), 64'(0));
            if (pready) begin
                check("pready_single_cycle", 64'(p_pready), 64'(0));
                if (exp_apb.size() == 0) check("apb_unexpected", 64'(1), 64'(0));
                else begin
                    e = exp_apb.pop_front();
                    check("prdata", 64'(prdata), 64'(e[31:0]));
                    check("pslverr", 64'(pslverr), 64'(e[32]));
                end
            end
            p_aw = awvalid && !awready; p_awaddr = awaddr;
            p_w  = wvalid && !wready;   p_wdata  = wdata;
            p_ar = arvalid && !arready; p_araddr = araddr;
            p_pready = pready;
        end
    end

    // ---------------- APB master / stimulus -----------------------------
    task automatic apb_start(input txn_t t);
        cur = t;
        if (t.wr) begin
            exp_aw.push_back({t.addr, t.prot});
            exp_w.push_back({t.data, ref_strb(t.strb)});
            exp_apb.push_back({ref_err(t.resp), 32'h0});
        end else begin
            exp_ar.push_back({t.addr, t.prot});
            exp_apb.push_back({ref_err(t.resp), t.rdata});
        end
        @(negedge clk);
        psel = 1; penable = 0; pwrite = t.wr; paddr = t.addr; pwdata = t.data; pprot = t.prot;
`ifdef APB2AXIL_PSTRB_EN
        pstrb = t.strb;
`endif
        @(negedge clk);
        penable = 1;
    endtask

    task automatic apb_xfer(input txn_t t);
        int lat;
        apb_start(t);
        lat = 0;
        forever begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (pready) break;
            if (lat > 300) begin
                compared++; mismatched++;
                $display("FAIL apb_timeout: pready still 0 after %0d cycles, expected completion", lat);
                break;
            end
        end
        psel = 0; penable = 0;
        if (t.aw_dly == 0 && t.w_dly == 0 && t.b_dly == 0 && t.ar_dly == 0 && t.r_dly == 0)
            check("latency", 64'(lat), 64'(4));
    endtask

    function automatic txn_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input logic [1:0] resp,
                                input int unsigned awd, input int unsigned wd, input int unsigned ard);
        txn_t t;
        t.wr = wr; t.addr = addr; t.data = data; t.strb = strb; t.prot = 3'd2;
        t.resp = resp; t.rdata = data;
        t.aw_dly = awd; t.w_dly = wd; t.b_dly = 0; t.ar_dly = ard; t.r_dly = 0;
        return t;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valids"}, 64'({awvalid, wvalid, arvalid}), 64'(0));
        check({tag, "_readies"}, 64'({bready, rready}), 64'(0));
        check({tag, "_apb"}, 64'({pready, pslverr}), 64'(0));
        check({tag, "_prdata"}, 64'(prdata), 64'(0));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        txn_t t;
        int n;
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");
        @(negedge clk); #2 rst_n = 1;

        apb_xfer(mk(1, 32'h1000, 32'hDEADBEEF, 4'hF, 2'b00, 0, 0, 0));
        apb_xfer(mk(1, 32'h1008, 32'hCAFEF00D, 4'hF, 2'b00, 3, 0, 0));
        apb_xfer(mk(0, 32'h2004, 32'h12345678, 4'hF, 2'b00, 0, 0, 5));
        apb_xfer(mk(0, 32'h2008, 32'hA5A5A5A5, 4'hF, 2'b11, 0, 0, 0));
        apb_xfer(mk(0, 32'h200C, 32'h0BADC0DE, 4'hF, 2'b00, 0, 0, 0));
        apb_xfer(mk(1, 32'h3000, 32'h11223344, 4'hF, 2'b10, 0, 0, 0));
        apb_xfer(mk(1, 32'h3004, 32'h55667788, 4'hF, 2'b00, 0, 0, 0));
        apb_xfer(mk(1, 32'h3008, 32'h99AABBCC, 4'b0101, 2'b00, 0, 0, 0));
        apb_xfer(mk(0, 32'h300C, 32'h13572468, 4'hF, 2'b01, 0, 2, 0));

        // reset while the write address is still waiting for awready
        apb_start(mk(1, 32'h4000, 32'hFEEDFACE, 4'hF, 2'b00, 50, 50, 0));
        n = 0;
        while (!awvalid && n < 20) begin @(negedge clk); n++; end
        check("awvalid_before_reset", 64'(awvalid), 64'(1));
        #2 rst_n = 0; psel = 0; penable = 0;
        @(posedge clk); #1;
        check_idle_outputs("midreset");
        exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_apb.delete();
        @(negedge clk); #2 rst_n = 1;
        apb_xfer(mk(0, 32'h4004, 32'h76543210, 4'hF, 2'b00, 0, 0, 0));

        for (int i = 0; i < 40; i++) begin
            t.wr = 1'($urandom_range(0, 1));
            t.addr = $urandom & 32'hFFFF_FFFC;
            t.data = $urandom;
            t.strb = 4'($urandom_range(0, 15));
            t.prot = 3'($urandom_range(0, 7));
            t.resp = 2'($urandom_range(0, 3));
            t.rdata = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                t.aw_dly = 0; t.w_dly = 0; t.b_dly = 0; t.ar_dly = 0; t.r_dly = 0;
            end else begin
                t.aw_dly = $urandom_range(0, 4); t.w_dly = $urandom_range(0, 4);
                t.b_dly = $urandom_range(0, 4); t.ar_dly = $urandom_range(0, 4);
                t.r_dly = $urandom_range(0, 4);
            end
            apb_xfer(t);
        end

        repeat (4) @(posedge clk);
        #1 check("queues_drained", 64'(exp_aw.size() + exp_w.size() + exp_ar.size() + exp_apb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
